// File: rtl/mem_init_loader.sv
// mem_init_loader: decodes framed host stream blocks into per-channel memory writes, then releases the CPU
module mem_init_loader #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int NUM_MEM = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               rearm,
  output logic [NUM_MEM-1:0] mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_data,
  output logic               cpu_hold,
  output logic               cpu_start,
  output logic               done,
  output logic               err
);
  localparam int CH_W = NUM_MEM > 1 ? $clog2(NUM_MEM) : 1;
  localparam int FW   = DATA_W - 1 - ADDR_W;
  localparam logic [2:0] HDR = 3'd0, ADR = 3'd1, DAT = 3'd2, START = 3'd3, DONE = 3'd4, ERR = 3'd5;
  logic [2:0]        state;
  logic [CH_W-1:0]   ch;
  logic [ADDR_W-1:0] len, addr, cnt;
  logic              xfer, end_flag, bad_ch;
  logic [FW-1:0]     ch_field;
  assign xfer      = in_valid & in_ready;
  assign end_flag  = in_data[DATA_W-1];
  // every non-END header bit above LEN is treated as channel number so stray high bits flag an error
  assign ch_field  = in_data[DATA_W-2:ADDR_W];
  assign bad_ch    = ch_field >= FW'(NUM_MEM);
  assign in_ready  = state == HDR || state == ADR || state == DAT;
  assign cpu_hold  = !(state == START || state == DONE);
  assign cpu_start = state == START;
  assign done      = state == DONE;
  assign err       = state == ERR;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HDR;
      mem_we   <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      ch       <= '0;
      len      <= '0;
      addr     <= '0;
      cnt      <= '0;
    end else begin
      mem_we <= '0;
      case (state)
        HDR: if (xfer) begin
          if (end_flag) state <= START;
          else if (bad_ch) state <= ERR;
          else begin
            ch    <= in_data[ADDR_W+CH_W-1:ADDR_W];
            len   <= in_data[ADDR_W-1:0];
            state <= ADR;
          end
        end
        ADR: if (xfer) begin
          addr  <= in_data[ADDR_W-1:0];
          cnt   <= '0;
          state <= DAT;
        end
        DAT: if (xfer) begin
          mem_we   <= NUM_MEM'(1) << ch;
          mem_addr <= addr;
          mem_data <= in_data;
          addr     <= addr + 1'b1;
          cnt      <= cnt + 1'b1;
          state    <= cnt == len ? HDR : DAT;
        end
        START: state <= DONE;
        DONE: state <= rearm ? HDR : DONE;
        default: state <= ERR;
      endcase
    end
  end
endmodule
